led_matrix_scanner: RTL and testbench

Parametrised multiplexed LED-matrix driver. It succeeds the fixed 4x4 row scanner behind the binary-clock pixel map, and adds:
- configurable rows and columns;
- a blanking interval between rows for anti-ghosting;
- per-frame PWM brightness;
- polarity selection for row and column drive;
- tear-free shadow latching of the pixel image at frame boundaries.

It sits between the clock/time formatting logic, which supplies the pixel vector, and the chip output pins.

---
 rtl/led_matrix_scanner.sv | 114 +++++++++++
 tb/tb_led_matrix_scanner.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/led_matrix_scanner.sv
// Multiplexed LED-matrix row scanner with per-row blanking, PWM brightness,
// selectable drive polarity and frame-boundary shadowing of the pixel image.
module led_matrix_scanner #(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int BLANK          = 2,
    parameter int PWM_BITS       = 4,
    parameter bit ROW_ACTIVE_LOW = 1'b1,
    parameter bit COL_ACTIVE_LOW = 1'b0,
    localparam int RW            = $clog2(ROWS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [ROWS*COLS-1:0] pixels,
    input  logic [PWM_BITS-1:0]  brightness,
    output logic [ROWS-1:0]      row_drive,
    output logic [COLS-1:0]      col_drive,
    output logic [RW-1:0]        row_idx,
    output logic                 frame_start
);
    localparam int ON = 1 << PWM_BITS;
    localparam int S  = BLANK + ON;
    localparam int CW = $clog2(S);
    localparam int KW = (CW > PWM_BITS) ? CW : PWM_BITS;

    localparam logic [CW-1:0] S_LAST   = CW'(S - 1);
    localparam logic [CW-1:0] BLANK_C  = CW'(BLANK);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

    logic                 active_q, active_d;
    logic [RW-1:0]        row_q, row_d;
    logic [CW-1:0]        cyc_q, cyc_d;
    logic [ROWS*COLS-1:0] spix_q, spix_d;
    logic [PWM_BITS-1:0]  sbri_q, sbri_d;

    always_comb begin
        active_d = active_q;
        row_d    = row_q;
        cyc_d    = cyc_q;
        spix_d   = spix_q;
        sbri_d   = sbri_q;
        if (!enable) begin
            // Idle: keep shadows tracking the inputs so the first frame is current.
            active_d = 1'b0;
            row_d    = '0;
            cyc_d    = '0;
            spix_d   = pixels;
            sbri_d   = brightness;
        end else if (!active_q) begin
            active_d = 1'b1;
        end else if (cyc_q == S_LAST) begin
            cyc_d = '0;
            if (row_q == ROW_LAST) begin
                row_d  = '0;
                spix_d = pixels;
                sbri_d = brightness;
            end else begin
                row_d = row_q + 1'b1;
            end
        end else begin
            cyc_d = cyc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            row_q    <= '0;
            cyc_q    <= '0;
            spix_q   <= '0;
            sbri_q   <= '0;
        end else begin
            active_q <= active_d;
            row_q    <= row_d;
            cyc_q    <= cyc_d;
            spix_q   <= spix_d;
            sbri_q   <= sbri_d;
        end
    end

    logic in_blank;
    generate
        if (BLANK == 0) begin : g_noblank
            assign in_blank = 1'b0;
        end else begin : g_blank
            assign in_blank = (cyc_q < BLANK_C);
        end
    endgenerate

    logic            on_phase;
    logic            pwm_lit;
    logic [KW-1:0]   k_w;
    logic [COLS-1:0] row_bits;

    // k == sbri..ON-1 is dark, so full-scale brightness leaves the last on-cycle off.
    assign on_phase = active_q && !in_blank;
    assign k_w      = KW'(cyc_q - BLANK_C);
    assign pwm_lit  = (k_w < KW'(sbri_q));
    assign row_bits = spix_q[row_q*COLS +: COLS];

    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            row_drive[r] = (on_phase && (row_q == RW'(r))) ? ~ROW_ACTIVE_LOW : ROW_ACTIVE_LOW;
        end
        for (int c = 0; c < COLS; c++) begin
            col_drive[c] = (on_phase && pwm_lit && row_bits[c]) ? ~COL_ACTIVE_LOW : COL_ACTIVE_LOW;
        end
    end

    assign row_idx     = row_q;
    assign frame_start = active_q && (row_q == '0) && (cyc_q == '0);

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench: default 4x4 scanner plus an 8x2 active-high-row / active-low-column variant.
module tb_led_matrix_scanner;
    logic        clk = 1'b0;
    logic        rst, enable, enable2;
    logic [15:0] pixels, pixels2;
    logic [3:0]  brightness;
    logic [1:0]  brightness2;
    logic [3:0]  row_drive, col_drive;
    logic [1:0]  row_idx;
    logic        frame_start;
    logic [7:0]  row_drive2;
    logic [1:0]  col_drive2;
    logic [2:0]  row_idx2;
    logic        frame_start2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    led_matrix_scanner dut (
        .clk(clk), .rst(rst), .enable(enable), .pixels(pixels), .brightness(brightness),
        .row_drive(row_drive), .col_drive(col_drive), .row_idx(row_idx), .frame_start(frame_start)
    );

    led_matrix_scanner #(
        .ROWS(8), .COLS(2), .BLANK(0), .PWM_BITS(2), .ROW_ACTIVE_LOW(1'b0), .COL_ACTIVE_LOW(1'b1)
    ) dut2 (
        .clk(clk), .rst(rst), .enable(enable2), .pixels(pixels2), .brightness(brightness2),
        .row_drive(row_drive2), .col_drive(col_drive2), .row_idx(row_idx2), .frame_start(frame_start2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".row"}, 32'(row_drive), 32'hF);
        chk({tag, ".col"}, 32'(col_drive), 32'h0);
        chk({tag, ".idx"}, 32'(row_idx), 32'h0);
        chk({tag, ".fs"},  32'(frame_start), 32'h0);
    endtask

    // Checks frame offsets lo..hi of the default instance; caller sits at offset lo, leaves at hi.
    task automatic frame_chk(input string tag, input logic [15:0] pix, input int bri,
                             input int lo, input int hi);
        for (int o = lo; o <= hi; o++) begin
            int r, cyc;
            logic [3:0] erd, ecd, rowpix;
            r      = o / 18;
            cyc    = o % 18;
            rowpix = pix[r*4 +: 4];
            erd    = (cyc < 2) ? 4'hF : (4'hF & ~(4'h1 << r));
            ecd    = (cyc >= 2 && (cyc - 2) < bri) ? rowpix : 4'h0;
            chk({tag, ".row"}, 32'(row_drive), 32'(erd));
            chk({tag, ".col"}, 32'(col_drive), 32'(ecd));
            chk({tag, ".idx"}, 32'(row_idx), 32'(r));
            chk({tag, ".fs"},  32'(frame_start), 32'(o == 0));
            if (o != hi) tick();
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; pixels = 16'hFFFF; brightness = 4'd15;
        enable2 = 1'b0; pixels2 = 16'hFFFF; brightness2 = 2'd3;

        // Reset held: everything inactive
        repeat (3) begin
            tick();
            chk("rst.row", 32'(row_drive), 32'hF);
            chk("rst.col", 32'(col_drive), 32'h0);
            chk("rst.fs",  32'(frame_start), 32'h0);
        end
        rst = 1'b0;
        chk("pre_act.fs", 32'(frame_start), 32'h0);
        tick();
        pixels = 16'h8421;
        frame_chk("dark1", 16'h0000, 0, 0, 71);

        tick();
        brightness = 4'd0;
        frame_chk("scan", 16'h8421, 15, 0, 71);

        tick();
        brightness = 4'd5;
        frame_chk("bri0", 16'h8421, 0, 0, 71);

        tick();
        pixels = 16'h000F; brightness = 4'd15;
        frame_chk("bri5", 16'h8421, 5, 0, 71);

        // Pixel change mid-frame must not tear the current frame
        tick();
        frame_chk("tear_a", 16'h000F, 15, 0, 29);
        tick();
        pixels = 16'hF000;
        frame_chk("tear_a", 16'h000F, 15, 30, 71);
        tick();
        pixels = 16'hFFFF;
        frame_chk("tear_b", 16'hF000, 15, 0, 71);

        // Enable dropped mid-frame
        tick();
        frame_chk("run", 16'hFFFF, 15, 0, 40);
        enable = 1'b0;
        tick();
        chk_idle("dis");
        pixels = 16'h0001;
        tick();
        chk_idle("dis2");
        tick();
        enable = 1'b1;
        tick();
        frame_chk("restart", 16'h0001, 15, 0, 50);

        // Reset pulse mid-frame: restart with dark frame
        rst = 1'b1;
        tick();
        chk_idle("rstmid");
        rst = 1'b0;
        pixels = 16'hFFFF;
        tick();
        frame_chk("rst_dark", 16'h0000, 0, 0, 71);
        tick();
        frame_chk("rst_lit", 16'hFFFF, 15, 0, 17);

        // Variant: 8x2, no blank, 2-bit PWM, rows active-high, columns active-low
        chk("v.idle.row", 32'(row_drive2), 32'h00);
        chk("v.idle.col", 32'(col_drive2), 32'h3);
        enable2 = 1'b1;
        tick();
        for (int t = 0; t < 64; t++) begin
            int r, c;
            r = (t / 4) % 8;
            c = t % 4;
            chk("v.row",    32'(row_drive2), 32'(8'h01 << r));
            chk("v.col",    32'(col_drive2), (c < 3) ? 32'h0 : 32'h3);
            chk("v.idx",    32'(row_idx2), 32'(r));
            chk("v.fs",     32'(frame_start2), 32'(t % 32 == 0));
            chk("v.onehot", 32'($countones(row_drive2)), 32'd1);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
